// File: rtl/instr_decode_ctrl.sv
// instr_decode_ctrl: multi-cycle decode/control stage ahead of the register
// file and ALU. One 16-bit word is accepted per valid/ready handshake, decoded
// into datapath controls, and walked through IDLE -> DECODE -> EXEC -> WB so the
// write/flag strobes only fire once operands and ALU result have settled.
// Build option: define REG_ZERO_LOCK_EN to make r0 read-only (write to rd=0
// suppresses reg_enable; flag_en is unaffected).
module instr_decode_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [3:0]  sel_a,
  output logic [3:0]  sel_b,
  output logic [7:0]  alu_op,
  output logic [15:0] imm,
  output logic        imm_sel,
  output logic [15:0] reg_enable,
  output logic        flag_en,
  output logic        illegal
);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 4) begin : g_bad_exec_cycles
    $error("instr_decode_ctrl: EXEC_CYCLES must be in 1..4");
  end

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  localparam logic [7:0] OP_NONE = 8'h17;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_exec_cnt;
  logic        w_accept;

  logic [3:0]  r_sel_a, r_sel_b, r_rd;
  logic [7:0]  r_alu_op;
  logic [15:0] r_imm;
  logic        r_imm_sel, r_we, r_flag, r_ill;

  logic [3:0]  w_op, w_rd, w_ext, w_rs;
  logic [3:0]  w_sel_a, w_sel_b;
  logic [7:0]  w_alu_op;
  logic [15:0] w_imm;
  logic        w_imm_sel, w_we, w_flag, w_ill;

  assign w_op     = instr[15:12];
  assign w_rd     = instr[11:8];
  assign w_ext    = instr[7:4];
  assign w_rs     = instr[3:0];
  assign w_accept = instr_valid && (r_state == S_IDLE);

  // Combinational decode of the presented word; anything not matched stays illegal.
  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_alu_op  = OP_NONE;
    w_imm     = '0;
    w_imm_sel = 1'b0;
    w_we      = 1'b0;
    w_flag    = 1'b0;
    w_ill     = 1'b1;
    if (instr == 16'h0000) begin
      w_ill = 1'b0;
    end else begin
      case (w_op)
        4'b0000: begin
          w_ill = 1'b0;
          w_we  = 1'b1;
          w_flag = 1'b1;
          case (w_ext)
            4'b0101: w_alu_op = 8'h00;
            4'b0110: w_alu_op = 8'h02;
            4'b1001: w_alu_op = 8'h08;
            4'b1011: begin w_alu_op = 8'h0A; w_we = 1'b0; end
            4'b0001: w_alu_op = 8'h0D;
            4'b0010: w_alu_op = 8'h0E;
            4'b0011: w_alu_op = 8'h0F;
            default: begin w_ill = 1'b1; w_we = 1'b0; w_flag = 1'b0; end
          endcase
          if (!w_ill) begin
            w_sel_a = w_rd;
            w_sel_b = w_rs;
          end
        end
        4'b0101, 4'b0110, 4'b1001, 4'b1011: begin
          w_ill     = 1'b0;
          w_flag    = 1'b1;
          w_we      = (w_op != 4'b1011);
          w_sel_a   = w_rd;
          w_imm_sel = 1'b1;
          w_imm     = (w_op == 4'b0110) ? {8'h00, instr[7:0]} : {{8{instr[7]}}, instr[7:0]};
          case (w_op)
            4'b0101: w_alu_op = 8'h01;
            4'b0110: w_alu_op = 8'h03;
            4'b1001: w_alu_op = 8'h09;
            default: w_alu_op = 8'h0B;
          endcase
        end
        4'b1000: begin
          case (w_ext)
            4'b0100: begin
              w_ill = 1'b0; w_we = 1'b1; w_alu_op = 8'h11;
              w_sel_a = w_rd; w_sel_b = w_rs;
            end
            4'b0000, 4'b0001: begin
              w_ill = 1'b0; w_we = 1'b1; w_sel_a = w_rd;
              w_alu_op  = (w_ext == 4'b0000) ? 8'h12 : 8'h14;
              w_imm     = {12'h000, w_rs};
              w_imm_sel = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
`ifdef REG_ZERO_LOCK_EN
    if (w_rd == 4'd0) w_we = 1'b0;
`endif
  end

  // State register and EXEC settle counter.
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_exec_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_exec_cnt <= (r_state == S_EXEC) ? r_exec_cnt + 2'd1 : '0;
    end
  end

  // Next-state sequencing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   if (r_exec_cnt == 2'(EXEC_CYCLES - 1)) w_next = S_WB;
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Captured decode: loaded on accept, held through WB, cleared on the way back to IDLE.
  always_ff @(posedge Clock) begin
    if (reset || r_state == S_WB) begin
      r_sel_a   <= '0;
      r_sel_b   <= '0;
      r_rd      <= '0;
      r_alu_op  <= '0;
      r_imm     <= '0;
      r_imm_sel <= 1'b0;
      r_we      <= 1'b0;
      r_flag    <= 1'b0;
      r_ill     <= 1'b0;
    end else if (w_accept) begin
      r_sel_a   <= w_sel_a;
      r_sel_b   <= w_sel_b;
      r_rd      <= w_rd;
      r_alu_op  <= w_alu_op;
      r_imm     <= w_imm;
      r_imm_sel <= w_imm_sel;
      r_we      <= w_we;
      r_flag    <= w_flag;
      r_ill     <= w_ill;
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign sel_a       = r_sel_a;
  assign sel_b       = r_sel_b;
  assign alu_op      = r_alu_op;
  assign imm         = r_imm;
  assign imm_sel     = r_imm_sel;
  assign reg_enable  = (r_state == S_WB && r_we) ? (16'h0001 << r_rd) : '0;
  assign flag_en     = (r_state == S_WB) && r_flag;
  assign illegal     = (r_state == S_WB) && r_ill;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Scoreboard bench for instr_decode_ctrl: the stimulus process queues the
// expected decode of every issued word; the monitor detects each handshake and
// checks the whole DECODE..WB timeline plus idle cycles against that entry.
module tb_instr_decode_ctrl;
  localparam int unsigned N = 3;

  logic        Clock = 1'b0;
  logic        reset, instr_valid;
  logic [15:0] instr;
  logic        instr_ready, imm_sel, flag_en, illegal;
  logic [3:0]  sel_a, sel_b;
  logic [7:0]  alu_op;
  logic [15:0] imm, reg_enable;

  instr_decode_ctrl #(.EXEC_CYCLES(N)) u_dut (
    .Clock(Clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .sel_a(sel_a), .sel_b(sel_b), .alu_op(alu_op),
    .imm(imm), .imm_sel(imm_sel), .reg_enable(reg_enable), .flag_en(flag_en),
    .illegal(illegal)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] w;
    logic [3:0]  sa, sb;
    logic [7:0]  op;
    logic [15:0] imm;
    logic        isel;
    logic [15:0] ren;
    logic        fl, il;
    bit          b2b;
    int          abort;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference decode from the instruction-set tables.
  function automatic exp_t model(input logic [15:0] w);
    exp_t e;
    int   alu;
    bit   wr, fl, regform, immf, sx;
    logic [3:0] op, rd, ext, rs;
    op = w[15:12]; rd = w[11:8]; ext = w[7:4]; rs = w[3:0];
    alu = -1; wr = 0; fl = 0; regform = 0; immf = 0; sx = 0;
    e.w = w; e.sa = 0; e.sb = 0; e.op = 8'h17; e.imm = 0; e.isel = 0;
    e.ren = 0; e.fl = 0; e.il = 1; e.b2b = 0; e.abort = 0;
    if (w == 16'h0000) begin
      e.il = 0;
      return e;
    end
    if (op == 4'h0) begin
      regform = 1; fl = 1;
      case (ext)
        4'h5: alu = 'h00;  4'h6: alu = 'h02;  4'h9: alu = 'h08;
        4'hB: alu = 'h0A;  4'h1: alu = 'h0D;  4'h2: alu = 'h0E;
        4'h3: alu = 'h0F;  default: alu = -1;
      endcase
      wr = (alu != 'h0A);
    end else if (op == 4'h5 || op == 4'h6 || op == 4'h9 || op == 4'hB) begin
      immf = 1; fl = 1; sx = (op != 4'h6); wr = (op != 4'hB);
      alu = (op == 4'h5) ? 'h01 : (op == 4'h6) ? 'h03 : (op == 4'h9) ? 'h09 : 'h0B;
    end else if (op == 4'h8) begin
      wr = 1;
      if (ext == 4'h4) begin alu = 'h11; regform = 1; end
      else if (ext == 4'h0) alu = 'h12;
      else if (ext == 4'h1) alu = 'h14;
    end
    if (alu < 0) return e;
    e.il = 0;
    e.op = 8'(alu);
    e.sa = rd;
    e.fl = fl;
    if (regform) e.sb = rs;
    else begin
      e.isel = 1;
      if (immf) e.imm = sx ? 16'(signed'(w[7:0])) : 16'(w[7:0]);
      else      e.imm = 16'(rs);
    end
    if (wr) e.ren = 16'h0001 << rd;
`ifdef REG_ZERO_LOCK_EN
    if (rd == 4'd0) e.ren = 0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic issue(input logic [15:0] w, input bit b2b, input int abort);
    exp_t e;
    int   t;
    e = model(w);
    e.b2b = b2b;
    e.abort = abort;
    sbq.push_back(e);
    instr = w;
    instr_valid = 1'b1;
    t = 0;
    do begin
      @(negedge Clock);
      t++;
    end while (!instr_ready && t < 40);
    if (!instr_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: instr %h not accepted within 40 cycles", w);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "handshake stalled");
    end
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    logic [3:0]  exts[7];
    logic [3:0]  iops[4];
    exts = '{4'h5, 4'h6, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3};
    iops = '{4'h5, 4'h6, 4'h9, 4'hB};
    w = 16'($urandom);
    case ($urandom_range(0, 4))
      0: w = {4'h0, w[11:8], exts[$urandom_range(0, 6)], w[3:0]};
      1: w = {iops[$urandom_range(0, 3)], w[11:0]};
      2: w = {4'h8, w[11:8], 4'($urandom_range(0, 5)), w[3:0]};
      3: w = 16'h0000;
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: idle checks every free cycle, full timeline check after each handshake.
  initial begin
    exp_t e;
    int   cyc, last_acc;
    cyc = 0;
    last_acc = -100;
    forever begin
      @(negedge Clock);
      cyc++;
      if (reset) continue;
      check("idle_outputs",
            {instr_ready, sel_a, sel_b, alu_op, imm, imm_sel, reg_enable, flag_en, illegal},
            {1'b1, 51'h0});
      if (instr_valid && instr_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: handshake with no queued expectation, instr=%h", instr);
          continue;
        end
        e = sbq.pop_front();
        if (e.b2b) check("issue_gap", 64'(cyc - last_acc), 64'(3 + N));
        last_acc = cyc;
        for (int k = 1; k <= 2 + int'(N); k++) begin
          @(negedge Clock);
          cyc++;
          if (e.abort != 0 && k == e.abort) begin
            check("abort_strobes", {reg_enable, flag_en, illegal}, 18'h0);
            break;
          end
          check("busy_fields", {instr_ready, sel_a, sel_b, alu_op, imm, imm_sel},
                {1'b0, e.sa, e.sb, e.op, e.imm, e.isel});
          check("wb_strobes", {reg_enable, flag_en, illegal},
                (k == 2 + int'(N)) ? {e.ren, e.fl, e.il} : 18'h0);
        end
      end
    end
  end

  // Stimulus: directed words first, then a randomized stream with held-valid bursts.
  initial begin
    logic [15:0] dir[8];
    bit hold;
    dir = '{16'h0355, 16'h52FD, 16'h62FD, 16'hB705, 16'h8403, 16'hF000, 16'h0000, 16'h0051};
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    repeat (3) @(posedge Clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    foreach (dir[i]) begin
      issue(dir[i], 0, 0);
      instr_valid = 1'b0;
      @(posedge Clock);
      #1;
    end
    issue(16'h0355, 0, 0);
    issue(16'h52FD, 1, 0);
    instr_valid = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    issue(16'h0151, 0, 2);
    instr_valid = 1'b0;
    @(posedge Clock);
    #1 reset = 1'b1;
    @(posedge Clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    hold = 0;
    for (int i = 0; i < 200; i++) begin
      issue(rand_instr(), hold, 0);
      if ($urandom_range(0, 2) == 0) hold = 1;
      else begin
        hold = 0;
        instr_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge Clock);
        #1;
      end
    end
    instr_valid = 1'b0;
    repeat (2 * (N + 4)) @(posedge Clock);
    check("sb_drained", 64'(sbq.size()), 64'h0);
    finish_run();
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_decode_ctrl.md
Name: instr_decode_ctrl

Overview:
- Multi-cycle control stage directly upstream of the register-file/ALU datapath.
- Accepts one 16-bit instruction word per valid/ready handshake and decodes it into datapath controls:
  - operand-A/B register selects
  - ALU opcode and immediate select
  - sign/zero-extended immediate
  - one-hot register write enable and flag-register enable
- Sequences IDLE -> DECODE -> EXEC -> WB so mux and ALU outputs settle before the write strobe.

Parameters:
- EXEC_CYCLES, 1, number of EXEC settle cycles; legal range 1..4; other values are a synthesis error.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  upstream has an instruction on instr.
- instr  in  16  instruction word.
- instr_ready  out  1  high only in IDLE.
- sel_a  out  4  operand-A register select (Rdest field).
- sel_b  out  4  operand-B register select (Rsrc field).
- alu_op  out  8  ALU opcode.
- imm  out  16  extended immediate.
- imm_sel  out  1  1 = ALU B input takes imm.
- reg_enable  out  16  one-hot write enable; nonzero only in WB.
- flag_en  out  1  flag-register load strobe; WB only.
- illegal  out  1  one-cycle pulse in WB for an undecodable word.

Behaviour:
- Reset: state=IDLE, captured instruction cleared. All outputs 0 except instr_ready=1. Applies from any state; an in-flight instruction is discarded with no write or flag strobe.
- Handshake: capture on a rising edge where instr_valid && instr_ready. instr_valid is ignored outside IDLE. The upstream holds instr until accepted.
- Timeline (accept edge = t0):
  - DECODE = cycle 1.
  - EXEC = cycles 2..1+EXEC_CYCLES.
  - WB = cycle 2+EXEC_CYCLES.
  - IDLE follows.
  - Issue rate: one instruction per 3+EXEC_CYCLES cycles.
- sel_a, sel_b, alu_op, imm and imm_sel are registered on entry to DECODE and held constant through WB. They return to 0 in IDLE.
- Fields: op=[15:12], rd=[11:8], ext=[7:4], rs=[3:0], imm8=[7:0].
- Register-register form (op=0000), sel_a=rd, sel_b=rs, imm_sel=0:
  - ext 0101 ADD 0x00
  - ext 0110 ADDU 0x02
  - ext 1001 SUB 0x08
  - ext 1011 CMP 0x0A
  - ext 0001 AND 0x0D
  - ext 0010 OR 0x0E
  - ext 0011 XOR 0x0F
- Immediate form, sel_a=rd, imm_sel=1:
  - op 0101 ADDI 0x01, imm=sext(imm8)
  - op 0110 ADDUI 0x03, imm=zext(imm8)
  - op 1001 SUBI 0x09, sext
  - op 1011 CMPI 0x0B, sext
- Shift form (op=1000):
  - ext 0100 LSH 0x11, register form.
  - ext 0000 LSHI 0x12, imm=zext(instr[3:0]), imm_sel=1.
  - ext 0001 RSHI 0x14, imm=zext(instr[3:0]), imm_sel=1.
- NOP: instr 16'h0000 -> alu_op 0x17; no write, no flag strobe, not illegal.
- WB strobes:
  - reg_enable = 1<<rd for every decoded op except CMP, CMPI and NOP.
  - flag_en = 1 for ADD, ADDU, SUB, CMP, AND, OR, XOR and the immediate-form arithmetic ops.
  - flag_en = 0 for shifts and NOP.
- Illegal: any other encoding.
  - alu_op=0x17; reg_enable and flag_en stay 0.
  - illegal=1 for the WB cycle only.
- reg_enable has at most one bit set. It is 0 in every state other than WB.

Optional Feature:
- Macro: REG_ZERO_LOCK_EN.
- Defined: register r0 is read-only. A decoded write with rd=0 produces reg_enable=0 in WB; flag_en behaves as normal and illegal stays 0.
- Undefined: r0 is written like any other register (reg_enable=16'h0001).

Test Plan:
- ADD r3,r5 (instr 16'h0355), EXEC_CYCLES=1 -> cycles 1-3: sel_a=3, sel_b=5, alu_op=0x00, imm_sel=0. Cycle 3: reg_enable=16'h0008, flag_en=1. Cycle 4: instr_ready=1.
- ADDI r2,-3 (16'h52FD) -> imm=16'hFFFD, imm_sel=1, alu_op=0x01. WB: reg_enable=16'h0004, flag_en=1. ADDUI r2,#0xFD (16'h62FD) -> imm=16'h00FD, alu_op=0x03.
- CMPI r7,#5 (16'hB705) -> alu_op=0x0B, imm=16'h0005. WB: reg_enable=0, flag_en=1. LSHI r4,#3 (16'h8403) -> alu_op=0x12, imm=3, WB reg_enable=16'h0010, flag_en=0.
- Illegal 16'hF000 -> alu_op=0x17; WB: illegal=1 for one cycle, reg_enable=0, flag_en=0. NOP 16'h0000 -> no strobes, illegal=0.
- instr_valid held high with two words -> second accepted exactly 4 cycles after the first (EXEC_CYCLES=1), 6 cycles after (EXEC_CYCLES=3). instr_ready is 0 between acceptances.
- Reset asserted during EXEC of ADD r1,r1 (16'h0151) -> next cycle all outputs 0 except instr_ready=1; no reg_enable/flag_en pulse ever seen. With REG_ZERO_LOCK_EN, ADD r0,r1 (16'h0051) -> WB reg_enable=0, flag_en=1.
